// File: rtl/ysyx_22050499_bus_arbiter_if.sv
// ysyx_22050499_bus_arbiter_if
//   AXI4 master-side bus shared by the IFU/MEM arbiter and the interconnect.
//   Channels:
//     AR : arvalid, arready, araddr[31:0], arlen[7:0], arsize[2:0], arburst[1:0]
//     R  : rvalid, rready, rdata[31:0], rresp[1:0], rlast
//     AW : awvalid, awready, awaddr[31:0], awsize[2:0]
//     W  : wvalid, wready, wdata[31:0], wstrb[3:0], wlast
//     B  : bvalid, bready, bresp[1:0]
//   Modports:
//     master : the arbiter (drives valid/payload on AR/AW/W, ready on R/B)
//     slave  : the interconnect or a memory model
interface ysyx_22050499_bus_arbiter_if;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;

  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;

  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic [2:0]  awsize;

  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;

  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;

  modport master (
    output arvalid, araddr, arlen, arsize, arburst,
    input  arready,
    input  rvalid, rdata, rresp, rlast,
    output rready,
    output awvalid, awaddr, awsize,
    input  awready,
    output wvalid, wdata, wstrb, wlast,
    input  wready,
    input  bvalid, bresp,
    output bready
  );

  modport slave (
    input  arvalid, araddr, arlen, arsize, arburst,
    output arready,
    output rvalid, rdata, rresp, rlast,
    input  rready,
    input  awvalid, awaddr, awsize,
    output awready,
    input  wvalid, wdata, wstrb, wlast,
    output wready,
    output bvalid, bresp,
    input  bready
  );
endinterface

// File: rtl/ysyx_22050499_bus_arbiter.sv
// ysyx_22050499_bus_arbiter
//   Shares one AXI4 master port between the IFU (burst line refills) and the
//   MEM stage (single-beat loads/stores). All AXI outputs are registered.
//   Ports:
//     clock, reset (async, active-low)
//     if_req/if_kill/if_addr   -> if_done/if_line   IFU line refill
//     mem_req/mem_we/mem_addr/mem_size/mem_wdata/mem_wstrb
//                              -> mem_done/mem_rdata MEM access
//     bus_err                  pulses with a done on a bad response or burst length
//     io_master                AXI4 master bus (ysyx_22050499_bus_arbiter_if.master)
//   Configuration:
//     YSYX_22050499_RR_ARB_EN defined   : round-robin between IFU and MEM
//     YSYX_22050499_RR_ARB_EN undefined : fixed priority, MEM over IFU
module ysyx_22050499_bus_arbiter #(
  parameter int LINE_BEATS = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       if_req,
  input  logic                       if_kill,
  input  logic [31:0]                if_addr,
  output logic                       if_done,
  output logic [32*LINE_BEATS-1:0]   if_line,
  input  logic                       mem_req,
  input  logic                       mem_we,
  input  logic [31:0]                mem_addr,
  input  logic [2:0]                 mem_size,
  input  logic [31:0]                mem_wdata,
  input  logic [3:0]                 mem_wstrb,
  output logic                       mem_done,
  output logic [31:0]                mem_rdata,
  output logic                       bus_err,
  ysyx_22050499_bus_arbiter_if.master io_master
);
  localparam int LINE_BYTES = LINE_BEATS * 4;
  localparam int CNT_W = $clog2(LINE_BEATS) + 1;
  localparam int LW = 32 * LINE_BEATS;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_BEATS - 1);
  localparam logic [CNT_W-1:0] BEATS_CNT = CNT_W'(LINE_BEATS);
  localparam logic [1:0] BURST_INCR = 2'b01;

  typedef enum logic [2:0] {IDLE, IF_AR, IF_R, MEM_AR, MEM_R, MEM_AW, MEM_B} state_t;

  state_t           state_q, state_d;
  logic             kill_q, kill_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [LW-1:0]    line_buf_q, line_buf_d, line_next;
  logic             resp_err_q, resp_err_d;
  logic             aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic             arvalid_q, arvalid_d, rready_q, rready_d;
  logic [31:0]      araddr_q, araddr_d;
  logic [7:0]       arlen_q, arlen_d;
  logic [2:0]       arsize_q, arsize_d;
  logic [1:0]       arburst_q, arburst_d;
  logic             awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic [31:0]      awaddr_q, awaddr_d, wdata_q, wdata_d;
  logic [2:0]       awsize_q, awsize_d;
  logic [3:0]       wstrb_q, wstrb_d;
  logic             if_done_q, if_done_d, mem_done_q, mem_done_d, bus_err_q, bus_err_d;
  logic [LW-1:0]    if_line_q, if_line_d;
  logic [31:0]      mem_rdata_q, mem_rdata_d;
  logic             if_ok, mem_ok, grant_if, grant_mem;
  logic             ar_hs, r_hs, aw_hs, w_hs, b_hs;
  logic [CNT_W-2:0] beat_idx;

  assign ar_hs = arvalid_q & io_master.arready;
  assign r_hs  = rready_q & io_master.rvalid;
  assign aw_hs = awvalid_q & io_master.awready;
  assign w_hs  = wvalid_q & io_master.wready;
  assign b_hs  = bready_q & io_master.bvalid;

  // A requester is not eligible in the cycle its own done is visible, and an
  // IFU kill in IDLE vetoes the IFU grant for that cycle.
  assign if_ok  = if_req & ~if_done_q & ~if_kill;
  assign mem_ok = mem_req & ~mem_done_q;

`ifdef YSYX_22050499_RR_ARB_EN
  // rr_ptr_q = 0 favours IFU, 1 favours MEM; it flips to the loser of each grant.
  logic rr_ptr_q;
  assign grant_mem = mem_ok & (~if_ok | rr_ptr_q);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_ptr_q <= 1'b0;
    end else if (state_q == IDLE && (grant_if || grant_mem)) begin
      rr_ptr_q <= grant_if;
    end
  end
`else
  assign grant_mem = mem_ok;
`endif
  assign grant_if = if_ok & ~grant_mem;

  // Valids rise one edge after entering a request state (the first cycle in
  // that state sees valid low), then hold until their own handshake.
  always_comb begin
    state_d     = state_q;
    kill_d      = kill_q;
    cnt_d       = cnt_q;
    line_buf_d  = line_buf_q;
    resp_err_d  = resp_err_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    arvalid_d   = arvalid_q;
    araddr_d    = araddr_q;
    arlen_d     = arlen_q;
    arsize_d    = arsize_q;
    arburst_d   = arburst_q;
    rready_d    = rready_q;
    awvalid_d   = awvalid_q;
    awaddr_d    = awaddr_q;
    awsize_d    = awsize_q;
    wvalid_d    = wvalid_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    bready_d    = bready_q;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;
    bus_err_d   = 1'b0;
    if_line_d   = if_line_q;
    mem_rdata_d = mem_rdata_q;
    beat_idx    = cnt_q[CNT_W-2:0];
    // Beats past the end of the line are dropped; the length error flags them.
    line_next   = line_buf_q;
    if (cnt_q != BEATS_CNT) line_next[{beat_idx, 5'b0} +: 32] = io_master.rdata;

    case (state_q)
      IDLE: begin
        kill_d = 1'b0;
        if (grant_if) begin
          state_d    = IF_AR;
          araddr_d   = if_addr & ~32'(LINE_BYTES - 1);
          arlen_d    = 8'(LINE_BEATS - 1);
          arsize_d   = 3'd2;
          arburst_d  = BURST_INCR;
          cnt_d      = '0;
          line_buf_d = '0;
          resp_err_d = 1'b0;
        end else if (grant_mem) begin
          if (mem_we) begin
            state_d   = MEM_AW;
            awaddr_d  = mem_addr;
            awsize_d  = mem_size;
            wdata_d   = mem_wdata;
            wstrb_d   = mem_wstrb;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
          end else begin
            state_d   = MEM_AR;
            araddr_d  = mem_addr;
            arlen_d   = 8'd0;
            arsize_d  = mem_size;
            arburst_d = BURST_INCR;
          end
        end
      end
      IF_AR: begin
        if (if_kill) kill_d = 1'b1;
        arvalid_d = 1'b1;
        if (ar_hs) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = IF_R;
        end
      end
      IF_R: begin
        if (if_kill) kill_d = 1'b1;
        if (r_hs) begin
          line_buf_d = line_next;
          resp_err_d = resp_err_q | (io_master.rresp != 2'b00);
          if (cnt_q != BEATS_CNT) cnt_d = cnt_q + CNT_W'(1);
          if (io_master.rlast) begin
            state_d  = IDLE;
            rready_d = 1'b0;
            // A killed refill still drains the bus but never reports.
            if (!(kill_q || if_kill)) begin
              if_done_d = 1'b1;
              if_line_d = line_next;
              bus_err_d = resp_err_q | (io_master.rresp != 2'b00) | (cnt_q != LAST_BEAT);
            end
          end
        end
      end
      MEM_AR: begin
        arvalid_d = 1'b1;
        if (ar_hs) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = MEM_R;
        end
      end
      MEM_R: begin
        if (r_hs) begin
          state_d     = IDLE;
          rready_d    = 1'b0;
          mem_done_d  = 1'b1;
          mem_rdata_d = io_master.rdata;
          bus_err_d   = (io_master.rresp != 2'b00) | ~io_master.rlast;
        end
      end
      MEM_AW: begin
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q | w_hs;
        awvalid_d = ~aw_done_d;
        wvalid_d  = ~w_done_d;
        if (aw_done_d && w_done_d) begin
          state_d  = MEM_B;
          bready_d = 1'b1;
        end
      end
      MEM_B: begin
        if (b_hs) begin
          state_d    = IDLE;
          bready_d   = 1'b0;
          mem_done_d = 1'b1;
          bus_err_d  = (io_master.bresp != 2'b00);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      kill_q      <= 1'b0;
      cnt_q       <= '0;
      line_buf_q  <= '0;
      resp_err_q  <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      araddr_q    <= '0;
      arlen_q     <= '0;
      arsize_q    <= '0;
      arburst_q   <= '0;
      rready_q    <= 1'b0;
      awvalid_q   <= 1'b0;
      awaddr_q    <= '0;
      awsize_q    <= '0;
      wvalid_q    <= 1'b0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      bready_q    <= 1'b0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      bus_err_q   <= 1'b0;
      if_line_q   <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      kill_q      <= kill_d;
      cnt_q       <= cnt_d;
      line_buf_q  <= line_buf_d;
      resp_err_q  <= resp_err_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      arvalid_q   <= arvalid_d;
      araddr_q    <= araddr_d;
      arlen_q     <= arlen_d;
      arsize_q    <= arsize_d;
      arburst_q   <= arburst_d;
      rready_q    <= rready_d;
      awvalid_q   <= awvalid_d;
      awaddr_q    <= awaddr_d;
      awsize_q    <= awsize_d;
      wvalid_q    <= wvalid_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      bready_q    <= bready_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
      bus_err_q   <= bus_err_d;
      if_line_q   <= if_line_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  assign io_master.arvalid = arvalid_q;
  assign io_master.araddr  = araddr_q;
  assign io_master.arlen   = arlen_q;
  assign io_master.arsize  = arsize_q;
  assign io_master.arburst = arburst_q;
  assign io_master.rready  = rready_q;
  assign io_master.awvalid = awvalid_q;
  assign io_master.awaddr  = awaddr_q;
  assign io_master.awsize  = awsize_q;
  assign io_master.wvalid  = wvalid_q;
  assign io_master.wdata   = wdata_q;
  assign io_master.wstrb   = wstrb_q;
  assign io_master.wlast   = wvalid_q;
  assign io_master.bready  = bready_q;

  assign if_done   = if_done_q;
  assign if_line   = if_line_q;
  assign mem_done  = mem_done_q;
  assign mem_rdata = mem_rdata_q;
  assign bus_err   = bus_err_q;
endmodule
